// File: rtl/led_sched_pkg.sv
// Shared constants and helpers for the LED pattern scheduler: mode encodings,
// LED count, pattern state record and the LED decode function.
package led_sched_pkg;

    localparam int LED_COUNT = 4;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_e;

    typedef logic [LED_COUNT-1:0] led_vec_t;
    typedef logic [$clog2(LED_COUNT)-1:0] pos_t;

    localparam pos_t POS_FIRST = '0;
    localparam pos_t POS_LAST  = pos_t'(LED_COUNT - 1);

    // Complete pattern state; the FSM registers exactly this record.
    typedef struct packed {
        mode_e mode;
        pos_t  pos;
        logic  dir_down;
        logic  phase;
    } pattern_t;

    localparam pattern_t PATTERN_RESET = '{
        mode:     MODE_OFF,
        pos:      POS_FIRST,
        dir_down: 1'b0,
        phase:    1'b0
    };

    function automatic mode_e next_mode(input mode_e m);
        mode_e r;
        case (m)
            MODE_OFF:    r = MODE_BLINK;
            MODE_BLINK:  r = MODE_CHASE;
            MODE_CHASE:  r = MODE_BOUNCE;
            default:     r = MODE_OFF;
        endcase
        return r;
    endfunction

    function automatic led_vec_t decode_leds(input pattern_t p);
        led_vec_t v;
        v = '0;
        case (p.mode)
            MODE_BLINK:  v = {LED_COUNT{p.phase}};
            MODE_CHASE,
            MODE_BOUNCE: v[p.pos] = 1'b1;
            default:     v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step-rate tick generator: counts 0..period-1 and pulses tick on the last
// count. restart forces the count back to 0 so a new mode gets a full period.
module led_tick_gen #(
    parameter int period = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    if (period < 2) begin : g_period_check
        $error("led_tick_gen: period must be at least 2");
    end

    localparam int CW = (period < 2) ? 1 : $clog2(period);
    localparam logic [CW-1:0] LAST = CW'(period - 1);

    logic [CW-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (restart || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/led_pattern_scheduler.sv
// Button-driven LED pattern scheduler: synchronizes and debounces btn, cycles
// OFF/BLINK/CHASE/BOUNCE on each press, and steps the pattern on each tick.
module led_pattern_scheduler
    import led_sched_pkg::*;
#(
    parameter int clk_freq_hz     = 25000000,
    parameter int steps_per_sec   = 4,
    parameter int debounce_cycles = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    output logic       led1,
    output logic       led2,
    output logic       led3,
    output logic       led4,
    output logic [1:0] mode
);

    localparam int PERIOD = clk_freq_hz / steps_per_sec;
    localparam int DB_W   = $clog2(debounce_cycles + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(debounce_cycles - 1);

    if (PERIOD < 2) begin : g_period_check
        $error("led_pattern_scheduler: clk_freq_hz/steps_per_sec must be at least 2");
    end
    if (debounce_cycles < 1) begin : g_debounce_check
        $error("led_pattern_scheduler: debounce_cycles must be at least 1");
    end

    logic            sync_meta;
    logic            sync_q;
    logic [DB_W-1:0] db_cnt;
    logic            stable;
    logic            stable_prev;
    logic            press;
    logic            tick;
    pattern_t        state_q;
    pattern_t        state_d;
    led_vec_t        leds_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= btn;
            sync_q    <= sync_meta;
        end
    end

    // Stable level flips only after debounce_cycles consecutive disagreeing
    // samples; press is registered one cycle after a 0->1 flip.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt      <= '0;
            stable      <= 1'b0;
            stable_prev <= 1'b0;
            press       <= 1'b0;
        end else begin
            stable_prev <= stable;
            press       <= stable & ~stable_prev;
            if (sync_q != stable) begin
                if (db_cnt == DB_LAST) begin
                    stable <= sync_q;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    led_tick_gen #(
        .period (PERIOD)
    ) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .restart (press),
        .tick    (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PATTERN_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // press has priority: a coinciding tick is swallowed by the mode change.
    always_comb begin
        state_d = state_q;
        if (press) begin
            state_d          = PATTERN_RESET;
            state_d.mode     = next_mode(state_q.mode);
        end else if (tick) begin
            case (state_q.mode)
                MODE_BLINK: begin
                    state_d.phase = ~state_q.phase;
                end
                MODE_CHASE: begin
                    state_d.pos = (state_q.pos == POS_LAST) ? POS_FIRST : state_q.pos + 1'b1;
                end
                MODE_BOUNCE: begin
                    if (!state_q.dir_down) begin
                        if (state_q.pos == POS_LAST) begin
                            state_d.dir_down = 1'b1;
                            state_d.pos      = state_q.pos - 1'b1;
                        end else begin
                            state_d.pos      = state_q.pos + 1'b1;
                        end
                    end else begin
                        if (state_q.pos == POS_FIRST) begin
                            state_d.dir_down = 1'b0;
                            state_d.pos      = state_q.pos + 1'b1;
                        end else begin
                            state_d.pos      = state_q.pos - 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds_q <= '0;
        end else begin
            leds_q <= decode_leds(state_d);
        end
    end

    assign led1 = leds_q[0];
    assign led2 = leds_q[1];
    assign led3 = leds_q[2];
    assign led4 = leds_q[3];
    assign mode = state_q.mode;

endmodule

// File: doc/led_pattern_scheduler.md
LED_PATTERN_SCHEDULER -- requirements
Module: led_pattern_scheduler

Interface
REQ-001 Parameter clk_freq_hz, default 25000000, input clock frequency in Hz.
REQ-002 Parameter steps_per_sec, default 4, pattern steps per second.
REQ-003 Parameter debounce_cycles, default 250000, consecutive stable cycles needed to accept a button change.
REQ-004 Port clk  input  1  single system clock; all logic is clocked on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port btn  input  1  raw, asynchronous, active-high push button.
REQ-007 Port led1..led4  output  1 each  registered LED drives, active-high.
REQ-008 Port mode  output  2  current mode encoding: OFF=0, BLINK=1, CHASE=2, BOUNCE=3.

Function
REQ-009 Step period P SHALL equal clk_freq_hz/steps_per_sec using integer division; P<2 SHALL be an elaboration error.
REQ-010 The tick counter SHALL count 0..P-1 and wrap to 0; tick SHALL be a 1-cycle pulse asserted in the cycle where the count equals P-1.
REQ-011 btn SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Debounce: the stable level SHALL change only after the synchronized btn has differed from it for debounce_cycles consecutive cycles; any cycle of agreement SHALL clear the debounce count.
REQ-013 press SHALL be a 1-cycle pulse on each 0->1 transition of the stable level; release SHALL generate no event.
REQ-014 Mode FSM on press: OFF->BLINK->CHASE->BOUNCE->OFF; no other transitions.
REQ-015 On any mode change the block SHALL set position=0, direction=up and blink phase=0, and SHALL restart the tick counter at 0.
REQ-016 After a mode change, the first tick in the new mode SHALL occur a full P cycles later.
REQ-017 If press and tick coincide, press SHALL win and that tick SHALL have no pattern effect.
REQ-018 OFF mode: all LEDs SHALL be 0, and ticks SHALL be ignored.
REQ-019 BLINK mode: all four LEDs SHALL equal phase; phase SHALL toggle on each tick.
REQ-020 CHASE mode: exactly led(position+1) SHALL be lit; position SHALL advance 0,1,2,3,0,... per tick.
REQ-021 BOUNCE mode: exactly one LED SHALL be lit, with position following 0,1,2,3,2,1,0,1,... per tick; direction SHALL reverse at 3 and at 0 with no repeat of the end value.
REQ-022 LED outputs SHALL update on the clock edge after the tick/press cycle, giving 1-cycle latency.
REQ-023 mode SHALL reflect the new state on the clock edge after press.
REQ-024 Latency from a btn edge to press SHALL be 2 (synchronizer) + debounce_cycles + 1 cycles.

Reset
REQ-025 While rst is high, the block SHALL immediately and asynchronously force led1..led4=0 and mode=OFF.
REQ-026 While rst is high, the block SHALL also clear the tick counter, debounce counter, synchronizer flops, stable level, position and phase, and set direction=up.
REQ-027 Reset asserted mid-pattern or mid-debounce SHALL discard all progress; no press SHALL be generated by the reset edge itself.

Structure
REQ-028 Mode encodings, and the LED count of 4, SHALL be constants in a shared package led_sched_pkg.
REQ-029 Tick generation SHALL be a sub-module led_tick_gen with parameter period, inputs clk, rst and restart, and output tick.
REQ-030 Synchronizer, debounce, FSM and LED decode SHALL reside in led_pattern_scheduler.

Verification (clk_freq_hz=8, steps_per_sec=2 giving P=4; debounce_cycles=3)
REQ-031 Reset: assert rst mid-CHASE -> LEDs=0000 and mode=0 in the same cycle, without waiting for a clock edge.
REQ-032 Debounce: btn high 2 cycles then low -> no mode change; btn high for 6 or more cycles -> exactly one press, and mode=1.
REQ-033 BLINK: from mode=1, observe 16 cycles -> LEDs toggle 0000/1111 every 4 cycles, starting 0000 and becoming 1111 at the first tick.
REQ-034 BOUNCE: in mode=3, observe 7 ticks -> lit LED index sequence 1,2,3,4,3,2,1,2, starting from LED1.
REQ-035 Collision: align press with a tick in CHASE position 2 -> mode=3 with position 0; the next LED advance comes 4 cycles later.
REQ-036 Wrap: issue 4 presses from OFF -> mode sequence 1,2,3,0, with LEDs=0000 in OFF.
